// File: rtl/mux_pkg.sv
// Shared types and channel mapping for the mux scan sequencer family.
package mux_pkg;

  localparam int MUX_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  // S[1] selects at the first 2:1 level and S[0] at the output, so step k routes D[{k[0],k[1]}].
  function automatic logic [SEL_W-1:0] step_to_ch(input logic [SEL_W-1:0] step);
    return {step[0], step[1]};
  endfunction

endpackage

// File: rtl/mux_settle_counter.sv
// Loadable down-counter timing how long a mux select is held before sampling.
// o_expire is high when the count is at 1 or below, i.e. this is the last settle cycle.
module mux_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expire = (r_count <= CNT_W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through all channels, samples each after a settle time and publishes one atomic word.
// Optional MUX_SCAN_CONTINUOUS_EN: scans repeat back-to-back after the first start until reset.
module mux_scan_sequencer
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mux_y,
  output logic [SEL_W-1:0]  o_mux_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic [MUX_CH-1:0] o_sample,
  output logic              o_sample_valid
);

  localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam state_t           LP_RUN_ST = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

  state_t              r_state;
  logic [SEL_W-1:0]    r_step;
  logic [MUX_CH-1:0]   r_shadow;
  logic [MUX_CH-1:0]   r_sample;
  logic                r_sample_valid;

  state_t              w_state_nxt;
  logic                w_load;
  logic                w_dec;
  logic                w_expire;
  logic [MUX_CH-1:0]   w_shadow_nxt;

  mux_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (LP_SETTLE),
    .i_dec      (w_dec),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LP_RUN_ST;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (w_expire) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_dec = 1'b1;
        end
      end
      CAPTURE: begin
        if (r_step != SEL_W'(MUX_CH - 1)) begin
          w_state_nxt = LP_RUN_ST;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        w_state_nxt = LP_RUN_ST;
        w_load      = 1'b1;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shadow_nxt                     = r_shadow;
    w_shadow_nxt[step_to_ch(r_step)] = i_mux_y;
  end

  // Step wraps 3->0 on the last capture, which also returns the select to channel 0 for FINISH/IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_step         <= '0;
      r_shadow       <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CAPTURE) begin
        r_shadow <= w_shadow_nxt;
        r_step   <= r_step + SEL_W'(1);
        if (r_step == SEL_W'(MUX_CH - 1)) begin
          r_sample       <= w_shadow_nxt;
          r_sample_valid <= 1'b1;
        end
      end
    end
  end

  assign o_mux_sel      = r_step;
  assign o_done         = (r_state == FINISH);
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
`ifdef MUX_SCAN_CONTINUOUS_EN
  assign o_busy = (r_state != IDLE);
`else
  assign o_busy = (r_state == SETTLE) || (r_state == CAPTURE);
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Two sequencers (settle 1 and settle 0) checked every cycle against a phase-count model plus directed literals.
module tb_mux_scan_sequencer;

  localparam int S_A = 1;
  localparam int S_B = 0;

  logic       clk;
  logic       rst;
  logic       start [2];
  logic [3:0] d     [2];
  logic       mux_y [2];
  logic [1:0] sel   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [3:0] sample[2];
  logic       svalid[2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  int       m_phase [2];
  logic [3:0] m_cap    [2];
  logic [3:0] m_sample [2];
  logic       m_valid  [2];

  int exp_sel_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int got_sel_seq [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux routing: channel = 2*S[0] + S[1].
  function automatic int ch_of(input int k);
    return (k % 2) * 2 + (k / 2);
  endfunction

  function automatic int hold_of(input int u);
    return (u == 0) ? S_A + 1 : S_B + 1;
  endfunction

  assign mux_y[0] = d[0][ch_of(int'(sel[0]))];
  assign mux_y[1] = d[1][ch_of(int'(sel[1]))];

  mux_scan_sequencer #(.SETTLE_CYCLES(S_A), .CNT_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_mux_y(mux_y[0]),
    .o_mux_sel(sel[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_sample(sample[0]), .o_sample_valid(svalid[0])
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(S_B), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_mux_y(mux_y[1]),
    .o_mux_sel(sel[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_sample(sample[1]), .o_sample_valid(svalid[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Phase p = cycles since the accepting start edge; channel k is captured at the end of cycle (k+1)*H.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int p, h, k;
      p = m_phase[u];
      h = hold_of(u);
      if (rst) begin
        m_phase[u]  = 0;
        m_cap[u]    = 4'h0;
        m_sample[u] = 4'h0;
        m_valid[u]  = 1'b0;
      end else begin
        if (p >= 1 && p <= 4 * h && (p % h) == 0) begin
          k = p / h - 1;
          m_cap[u][ch_of(k)] = d[u][ch_of(k)];
          if (k == 3) begin
            m_sample[u] = m_cap[u];
            m_valid[u]  = 1'b1;
          end
        end
        if (p == 0)
          m_phase[u] = start[u] ? 1 : 0;
        else if (p == 4 * h + 1)
`ifdef MUX_SCAN_CONTINUOUS_EN
          m_phase[u] = 1;
`else
          m_phase[u] = 0;
`endif
        else
          m_phase[u] = p + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        int p, h, eb;
        p  = m_phase[u];
        h  = hold_of(u);
        eb = (p >= 1 && p <= 4 * h) ? 1 : 0;
`ifdef MUX_SCAN_CONTINUOUS_EN
        if (p == 4 * h + 1) eb = 1;
`endif
        chk($sformatf("model_busy[%0d]", u), int'(busy[u]), eb);
        chk($sformatf("model_sel[%0d]", u), int'(sel[u]), (p >= 1 && p <= 4 * h) ? (p - 1) / h : 0);
        chk($sformatf("model_done[%0d]", u), int'(done[u]), (p == 4 * h + 1) ? 1 : 0);
        chk($sformatf("model_sample[%0d]", u), int'(sample[u]), int'(m_sample[u]));
        chk($sformatf("model_valid[%0d]", u), int'(svalid[u]), int'(m_valid[u]));
      end
    end
  end

  initial begin
    int ndone;
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    d[0] = 4'h0; d[1] = 4'h0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_sample", int'(sample[0]), 0);
    chk("reset_valid", int'(svalid[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    rst = 1'b0;

    // Test 1: D=1010, settle 1.
    d[0] = 4'b1010;
    start[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start[0] = 1'b0;
      got_sel_seq[c-1] = int'(sel[0]);
      if (c < 9) chk("t1_no_early_done", int'(done[0]), 0);
    end
    chk("t1_done_c9", int'(done[0]), 1);
    chk("t1_sample", int'(sample[0]), 4'hA);
    chk("t1_valid", int'(svalid[0]), 1);
    for (int i = 0; i < 9; i++) chk($sformatf("t1_sel_seq[%0d]", i), got_sel_seq[i], exp_sel_seq[i]);
    repeat (2) @(negedge clk);

    // Test 2: D=0110, settle 0.
    d[1] = 4'b0110;
    start[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start[1] = 1'b0;
      if (c < 5) chk("t2_no_early_done", int'(done[1]), 0);
    end
    chk("t2_done_c5", int'(done[1]), 1);
    chk("t2_sample", int'(sample[1]), 4'h6);
    repeat (2) @(negedge clk);

    // Test 3: start re-pulsed mid-scan; D glitches while channel 0 settles.
    d[0] = 4'hC;
    start[0] = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start[0] = (c == 4) ? 1'b1 : 1'b0;
      d[0] = (c == 1) ? 4'h3 : 4'hC;
      if (done[0]) ndone++;
    end
    chk("t3_one_done", ndone, 1);
    chk("t3_sample", int'(sample[0]), 4'hC);

    // Test 4: reset in cycle 5 of a scan.
    d[0] = 4'hF;
    start[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", int'(busy[0]), 0);
    chk("t4_sel", int'(sel[0]), 0);
    chk("t4_sample", int'(sample[0]), 0);
    chk("t4_valid", int'(svalid[0]), 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    chk("t4_no_done", ndone, 0);

    // Test 5: start held high across two scans, D 3 then 5.
    d[0] = 4'h3;
    start[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 9) begin
        chk("t5_done1", int'(done[0]), 1);
        chk("t5_sample1", int'(sample[0]), 4'h3);
        d[0] = 4'h5;
      end
      if (c == 10) begin
        chk("t5_idle_gap_busy", int'(busy[0]), 0);
        chk("t5_idle_gap_done", int'(done[0]), 0);
      end
      if (c == 11) begin
        chk("t5_restart_busy", int'(busy[0]), 1);
        start[0] = 1'b0;
      end
      if (c == 19) begin
        chk("t5_done2", int'(done[0]), 1);
        chk("t5_sample2", int'(sample[0]), 4'h5);
      end
    end
    chk("t5_idle_after", int'(busy[0]), 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
